rtype_exec_ctrl: RTL and testbench
==================================

# rtype_exec_ctrl

Multi-cycle R-type execute controller that sits upstream and downstream of the combinational ALU. It accepts one 32-bit R-type instruction word per handshake and decodes rs/rt/rd/shamt/funct. It reads operands from an internal 32×32 register file, drives the ALU operand/control inputs, captures the ALU result and writes it back. It is the producer of the ALU's inputs and the consumer of its result.

## Interface
- No parameters; data width fixed at 32 bits, 32 registers.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instruction word present.
- `instr_ready`  out  1  controller can accept an instruction.
- `instr`  in  32  {opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]}.
- `init_we`, `init_addr`[5], `init_data`[32]  in  register preload port.
- `alu_src_data`  out  32  to ALU src operand (R[rs]).
- `alu_tar_data`  out  32  to ALU tar operand (R[rt]).
- `alu_shamt`  out  5  to ALU shift amount.
- `alu_funct`  out  6  to ALU function select.
- `alu_dst_data`  in  32  ALU result (combinational from the four outputs above).
- `wb_valid`  out  1  one-cycle pulse on register write-back.
- `wb_addr`  out  5  written register.
- `wb_data`  out  32  written value.
- `illegal`  out  1  one-cycle pulse on a rejected instruction.
- `dbg_addr`  in  5 / `dbg_data`  out  32  combinational register read; address 0 returns 0.

## Operation
- Legal instruction: opcode == 0 and funct ∈ {0x09 ADDU, 0x0A SUBU, 0x12 OR, 0x22 SRL}. Anything else is illegal.
- FSM states: IDLE → READ → EXEC → WB → IDLE.
- IDLE: `instr_ready`=1. On `instr_valid && instr_ready`, latch `instr` and go to READ.
- READ: register R[rs] and R[rt] into operand registers and check legality.
  - Illegal instruction: pulse `illegal` and return to IDLE.
  - Legal instruction: go to EXEC.
- EXEC: drive `alu_*` from the operand registers and latched shamt/funct. Capture `alu_dst_data` into the result register and go to WB.
- WB:
  - rd ≠ 0: write R[rd] and pulse `wb_valid` with `wb_addr`=rd, `wb_data`=result.
  - rd == 0: no write and no pulse.
  - Always return to IDLE.
- Outside EXEC, all `alu_*` outputs are 0.
- R0 always reads 0. Writes to R0 from any source are dropped.
- Preload: `init_we` is honored only in IDLE, including the accept cycle. READ therefore observes the preloaded value.
- Arithmetic is performed by the ALU: mod-2^32, no overflow detection. SRL is a logical shift of R[rs] by shamt.

## Timing
- Accept at edge 0. READ occupies cycle 1, EXEC cycle 2, WB cycle 3. `wb_valid` is high during cycle 3 and `instr_ready` returns in cycle 4.
- Throughput: one instruction per 4 cycles.
- Illegal instruction: `illegal` is high in cycle 2 and `instr_ready` returns in cycle 2.
- `instr_ready` is a registered function of state. Changes on `instr_valid`/`instr` outside IDLE are ignored.
- Reset values, applied at the next edge from any state: state=IDLE; all registers, operand registers and result register = 0; `instr_ready`=1; `wb_valid`=0; `wb_addr`=0; `wb_data`=0; `illegal`=0; `alu_*`=0.
- Reset mid-operation aborts the instruction with no write-back.

## Configuration
- Macro: `RTYPE_EXEC_ILLEGAL_TRAP_EN`.
- Defined:
  - An illegal instruction also sets a sticky trap flag.
  - While the flag is set, `instr_ready`=0 and the FSM stays in IDLE.
  - Only `rst` clears the flag.
- Undefined: illegal instructions are dropped after the `illegal` pulse and acceptance continues normally.

## Test plan
- Reset, preload R1=5 and R2=3, issue ADDU rd=3 rs=1 rt=2 → `wb_valid` 3 cycles after accept with `wb_addr`=3, `wb_data`=8, and `dbg_data`(3)=8.
- Preload R1=5 and R2=3, issue SUBU rd=4 rs=2 rt=1 → `wb_data`=0xFFFFFFFE. Issue OR rd=6 rs=1 rt=2 → 0x00000007.
- Preload R5=0x80000000, issue SRL rd=7 rs=5 shamt=4 → `wb_data`=0x08000000. During EXEC the bench checks `alu_funct`=0x22 and `alu_shamt`=4.
- Issue ADDU rd=0 rs=1 rt=2 → no `wb_valid`, `dbg_data`(0)=0. Hold `instr_valid`=1 continuously → accepts are spaced exactly 4 cycles apart.
- Issue funct=0x20 or opcode=0x08 → `illegal` pulse in cycle 2 and no write.
  - Macro undefined: the next instruction is accepted.
  - Macro defined: `instr_ready` stays 0 until `rst`.
- Assert `rst` during EXEC of ADDU rd=3 → next cycle IDLE with `instr_ready`=1, `dbg_data`(3)=0 and no `wb_valid`.

Source files
------------

// File: rtl/rtype_exec_ctrl.sv
// Multi-cycle R-type execute controller: decodes one instruction, feeds the external ALU from a
// 32x32 register file and writes the result back. Optional macro: RTYPE_EXEC_ILLEGAL_TRAP_EN.
module rtype_exec_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic        init_we,
  input  logic [4:0]  init_addr,
  input  logic [31:0] init_data,
  output logic [31:0] alu_src_data,
  output logic [31:0] alu_tar_data,
  output logic [4:0]  alu_shamt,
  output logic [5:0]  alu_funct,
  input  logic [31:0] alu_dst_data,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam logic [5:0] FunctAddu = 6'h09;
  localparam logic [5:0] FunctSubu = 6'h0A;
  localparam logic [5:0] FunctOr   = 6'h12;
  localparam logic [5:0] FunctSrl  = 6'h22;

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

  state_e      state_q;
  logic [31:0] instr_q;
  logic [31:0] src_q;
  logic [31:0] tar_q;
  logic [31:0] result_q;
  logic [31:0] regs_q [32];
  logic        instr_ready_q;
  logic        wb_valid_q;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_data_q;
  logic        illegal_q;
`ifdef RTYPE_EXEC_ILLEGAL_TRAP_EN
  logic        trap_q;
`endif

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] shamt;
  logic [5:0] funct;
  logic       legal;

  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign shamt  = instr_q[10:6];
  assign funct  = instr_q[5:0];

  always_comb begin
    legal = 1'b0;
    if (opcode == 6'd0) begin
      unique case (funct)
        FunctAddu, FunctSubu, FunctOr, FunctSrl: legal = 1'b1;
        default:                                 legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      instr_q       <= '0;
      src_q         <= '0;
      tar_q         <= '0;
      result_q      <= '0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      instr_ready_q <= 1'b1;
      wb_valid_q    <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      illegal_q     <= 1'b0;
`ifdef RTYPE_EXEC_ILLEGAL_TRAP_EN
      trap_q        <= 1'b0;
`endif
    end else begin
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Preload only lands in IDLE, so READ always sees it; R0 stays hard-wired to zero.
          if (init_we && (init_addr != 5'd0)) begin
            regs_q[init_addr] <= init_data;
          end
`ifdef RTYPE_EXEC_ILLEGAL_TRAP_EN
          if (trap_q) begin
            instr_ready_q <= 1'b0;
          end else
`endif
          if (instr_valid && instr_ready_q) begin
            instr_q       <= instr;
            instr_ready_q <= 1'b0;
            state_q       <= StRead;
          end
        end
        StRead: begin
          src_q <= regs_q[rs];
          tar_q <= regs_q[rt];
          if (legal) begin
            state_q <= StExec;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= StIdle;
`ifdef RTYPE_EXEC_ILLEGAL_TRAP_EN
            trap_q        <= 1'b1;
            instr_ready_q <= 1'b0;
`else
            instr_ready_q <= 1'b1;
`endif
          end
        end
        StExec: begin
          result_q <= alu_dst_data;
          state_q  <= StWb;
          if (rd != 5'd0) begin
            wb_valid_q <= 1'b1;
            wb_addr_q  <= rd;
            wb_data_q  <= alu_dst_data;
          end
        end
        StWb: begin
          if (rd != 5'd0) begin
            regs_q[rd] <= result_q;
          end
          instr_ready_q <= 1'b1;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The ALU sees quiet zero operands except while the instruction is executing.
  always_comb begin
    alu_src_data = '0;
    alu_tar_data = '0;
    alu_shamt    = '0;
    alu_funct    = '0;
    if (state_q == StExec) begin
      alu_src_data = src_q;
      alu_tar_data = tar_q;
      alu_shamt    = shamt;
      alu_funct    = funct;
    end
  end

  assign instr_ready = instr_ready_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign illegal     = illegal_q;
  assign dbg_data    = (dbg_addr == 5'd0) ? 32'd0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// Self-checking bench for rtype_exec_ctrl: directed plan steps plus randomized instructions
// checked against an architectural register/ALU model.
module tb_rtype_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic        init_we = 1'b0;
  logic [4:0]  init_addr = '0;
  logic [31:0] init_data = '0;
  logic [31:0] alu_src_data;
  logic [31:0] alu_tar_data;
  logic [4:0]  alu_shamt;
  logic [5:0]  alu_funct;
  logic [31:0] alu_dst_data;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int tests = 0;
  int fails = 0;
  logic [31:0] mregs [32];

  rtype_exec_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .init_we      (init_we),
    .init_addr    (init_addr),
    .init_data    (init_data),
    .alu_src_data (alu_src_data),
    .alu_tar_data (alu_tar_data),
    .alu_shamt    (alu_shamt),
    .alu_funct    (alu_funct),
    .alu_dst_data (alu_dst_data),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .illegal      (illegal),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  always #5 clk = ~clk;

  // Combinational ALU the controller drives.
  always_comb begin
    unique case (alu_funct)
      6'h09:   alu_dst_data = alu_src_data + alu_tar_data;
      6'h0A:   alu_dst_data = alu_src_data - alu_tar_data;
      6'h12:   alu_dst_data = alu_src_data | alu_tar_data;
      6'h22:   alu_dst_data = alu_src_data >> alu_shamt;
      default: alu_dst_data = 32'hDEAD_BEEF;
    endcase
  end

  function automatic logic [31:0] ref_result(input logic [5:0] fn, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] sh);
    if (fn == 6'h09) return a + b;
    if (fn == 6'h0A) return a - b;
    if (fn == 6'h12) return a | b;
    return a >> sh;
  endfunction

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    init_we = 1'b1;
    init_addr = a;
    init_data = d;
    tick();
    init_we = 1'b0;
    if (a != 5'd0) mregs[a] = d;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 12 && !instr_ready; i++) tick();
    check("ready_timeout", {31'd0, instr_ready}, 32'd1);
  endtask

  // Issues one instruction and checks every cycle of its lifetime against the model.
  task automatic run_instr(input logic [31:0] iw);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic        legal;
    logic [31:0] exp;
    op = iw[31:26]; rs = iw[25:21]; rt = iw[20:16]; rd = iw[15:11]; sh = iw[10:6]; fn = iw[5:0];
    legal = (op == 6'd0) && (fn == 6'h09 || fn == 6'h0A || fn == 6'h12 || fn == 6'h22);
    exp = ref_result(fn, mregs[rs], mregs[rt], sh);
    wait_ready();
    instr_valid = 1'b1;
    instr = iw;
    tick();
    // Cycle 1 (READ): garbage on instr must be ignored.
    instr = $urandom;
    check("read_ready", {31'd0, instr_ready}, 32'd0);
    check("read_alu_funct", {26'd0, alu_funct}, 32'd0);
    check("read_wb_valid", {31'd0, wb_valid}, 32'd0);
    tick();
    instr_valid = 1'b0;
    if (!legal) begin
      check("ill_pulse", {31'd0, illegal}, 32'd1);
      check("ill_wb_valid", {31'd0, wb_valid}, 32'd0);
`ifdef RTYPE_EXEC_ILLEGAL_TRAP_EN
      check("ill_ready_trap", {31'd0, instr_ready}, 32'd0);
      tick();
      check("ill_pulse_end", {31'd0, illegal}, 32'd0);
      check_reg("ill_no_write", rd, mregs[rd]);
      instr_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
        tick();
        check("trap_ready_low", {31'd0, instr_ready}, 32'd0);
      end
      instr_valid = 1'b0;
      do_reset();
      check("trap_ready_after_rst", {31'd0, instr_ready}, 32'd1);
`else
      check("ill_ready_back", {31'd0, instr_ready}, 32'd1);
      tick();
      check("ill_pulse_end", {31'd0, illegal}, 32'd0);
      check_reg("ill_no_write", rd, mregs[rd]);
`endif
    end else begin
      check("exec_src", alu_src_data, mregs[rs]);
      check("exec_tar", alu_tar_data, mregs[rt]);
      check("exec_shamt", {27'd0, alu_shamt}, {27'd0, sh});
      check("exec_funct", {26'd0, alu_funct}, {26'd0, fn});
      check("exec_illegal", {31'd0, illegal}, 32'd0);
      tick();
      check("wb_valid", {31'd0, wb_valid}, {31'd0, rd != 5'd0});
      if (rd != 5'd0) begin
        check("wb_addr", {27'd0, wb_addr}, {27'd0, rd});
        check("wb_data", wb_data, exp);
      end
      check("wb_alu_funct", {26'd0, alu_funct}, 32'd0);
      check("wb_ready", {31'd0, instr_ready}, 32'd0);
      tick();
      if (rd != 5'd0) mregs[rd] = exp;
      check("done_ready", {31'd0, instr_ready}, 32'd1);
      check("done_wb_valid", {31'd0, wb_valid}, 32'd0);
      check_reg("done_dbg", rd, mregs[rd]);
    end
  endtask

  initial begin
    int acc[$];
    logic saw_wb;
    logic [5:0] fn_tab [4];
    fn_tab[0] = 6'h09; fn_tab[1] = 6'h0A; fn_tab[2] = 6'h12; fn_tab[3] = 6'h22;

    // Reset state.
    #2;
    do_reset();
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_alu_src", alu_src_data, 32'd0);
    check_reg("rst_dbg5", 5'd5, 32'd0);

    // ADDU / SUBU / OR / SRL directed cases.
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd3);
    run_instr(enc(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h09));
    check_reg("addu_r3", 5'd3, 32'd8);
    run_instr(enc(6'd0, 5'd2, 5'd1, 5'd4, 5'd0, 6'h0A));
    check_reg("subu_r4", 5'd4, 32'hFFFF_FFFE);
    run_instr(enc(6'd0, 5'd1, 5'd2, 5'd6, 5'd0, 6'h12));
    check_reg("or_r6", 5'd6, 32'h0000_0007);
    preload(5'd5, 32'h8000_0000);
    run_instr(enc(6'd0, 5'd5, 5'd0, 5'd7, 5'd4, 6'h22));
    check_reg("srl_r7", 5'd7, 32'h0800_0000);

    // rd=0 and preload to R0 are dropped.
    preload(5'd0, 32'hFFFF_FFFF);
    run_instr(enc(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'h09));
    check_reg("r0_zero", 5'd0, 32'd0);

    // Back-to-back issue with valid held: accepts exactly 4 cycles apart.
    wait_ready();
    instr = enc(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'h09);
    instr_valid = 1'b1;
    saw_wb = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (instr_ready) acc.push_back(c);
      if (wb_valid) saw_wb = 1'b1;
      tick();
    end
    instr_valid = 1'b0;
    check("thru_count", acc.size(), 32'd5);
    for (int i = 1; i < acc.size(); i++) check("thru_spacing", acc[i] - acc[i-1], 32'd4);
    check("thru_no_wb", {31'd0, saw_wb}, 32'd0);
    wait_ready();

    // Illegal instructions leave the register file alone.
    run_instr(enc(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
    run_instr(enc(6'h08, 5'd1, 5'd2, 5'd4, 5'd0, 6'h09));
    if (mregs[1] == 32'd0) begin
      preload(5'd1, 32'd5);
      preload(5'd2, 32'd3);
    end
    run_instr(enc(6'd0, 5'd1, 5'd2, 5'd8, 5'd0, 6'h09));
    check_reg("post_ill_r8", 5'd8, 32'd8);

    // Reset during EXEC aborts the write-back.
    wait_ready();
    preload(5'd3, 32'h1234_5678);
    instr = enc(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h09);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    check("pre_rst_exec_funct", {26'd0, alu_funct}, 32'h09);
    do_reset();
    check("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
    check("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_reg("mid_rst_r3", 5'd3, 32'd0);
    tick();
    check("mid_rst_wb_later", {31'd0, wb_valid}, 32'd0);

    // Randomized instructions against the model.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] iw;
      preload(5'($urandom_range(1, 31)), $urandom);
      preload(5'($urandom_range(1, 31)), $urandom);
      iw = enc(6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               fn_tab[$urandom_range(0, 3)]);
      if ($urandom_range(0, 7) == 0) iw[5:0] = 6'h3F;
      run_instr(iw);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
